e203_icb_stim_slave: RTL
========================

Name: e203_icb_stim_slave

Overview:
- Parametrised, synthesizable ICB slave stimulus model; replaces flat all-zero/all-one/random input driving on fetch ports (ITCM/BIU side of e203_ifu benches) with a protocol-correct responder.
- Accepts commands, queues up to DEPTH outstanding, responds after programmable latency.
- Four data/backpressure modes from an internal LFSR; address-matched error injection.
- One instance per fetch channel.

Parameters:
- DW, 32: rsp_rdata width. Legal values: 32, 64.
- AW, 32: command address width.
- DEPTH, 4: maximum outstanding commands. Power of two, 2..16.
- LAT, 2: extra response latency in cycles, 0..15.
- SEED, 32'hACE1: LFSR reset value. 0 is replaced by 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mode  in  2  0=zeros, 1=ones, 2=random (data + backpressure), 3=address pattern
- err_en  in  1  enable error injection
- err_mask  in  AW  address mask for error match
- err_match  in  AW  error compare value
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_addr  in  AW  command address
- icb_cmd_read  in  1  1=read, 0=write
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_err  out  1  response error
- icb_rsp_rdata  out  DW  response data
- outstanding  out  $clog2(DEPTH+1)  queued entry count

Behaviour:
- Reset (async, active-high):
  - FIFO empty; outstanding=0; icb_cmd_ready=0 while rst is high.
  - icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0; hold flag=0; lfsr=SEED.
  - Reset mid-operation discards all queued entries; no response is ever issued for them.
- LFSR:
  - 32-bit Galois, taps 32'h80200003.
  - Advances every clk edge out of reset, independent of traffic.
- Command side:
  - icb_cmd_ready = !full && (mode!=2 || lfsr[0]). Combinational from registered state only; never from icb_cmd_valid.
  - Accept = valid && ready. Pushes {data, err, cnt=LAT}.
  - Full (outstanding==DEPTH) forces ready=0. No full-time pass-through, even if a pop occurs in the same cycle.
- Stored data, computed at accept; a later mode change affects subsequent accepts only:
  - mode 0: all zeros.
  - mode 1: all ones.
  - mode 2: lfsr replicated to DW.
  - mode 3: low 32 bits = addr (zero-extended); for DW=64, high 32 bits = ~addr.
  - Write commands (icb_cmd_read=0): data is always 0.
- Stored err = err_en && ((icb_cmd_addr & err_mask) == err_match).
- Latency counters:
  - Each entry counts down by 1 per cycle starting the cycle after accept, saturating at 0.
  - Command accepted at edge t: earliest rsp_valid is in cycle t+1+LAT. LAT=0 gives next-cycle response (no same-cycle bypass).
- Response side:
  - icb_rsp_valid = !empty && head.cnt==0 && (hold || mode!=2 || lfsr[1]).
  - hold is set when valid && !ready and cleared on handshake. Once asserted, valid and rdata/err stay stable until icb_rsp_ready.
  - rdata/err come from the FIFO head; they are 0 when valid is low.
  - Handshake pops the head. Responses are returned strictly in order.
- outstanding: +1 on accept, -1 on pop; unchanged when both happen in the same cycle.
- Empty FIFO: rsp_valid=0 regardless of mode.

Test Plan:
- Reset then idle, mode=0, cmd_valid=0 -> rsp_valid=0, outstanding=0, cmd_ready=1. Assert rst mid-cycle -> outputs go to 0 immediately, without waiting for a clock edge.
- mode=3, LAT=2, read addr 32'h8000_0010 accepted at edge t, rsp_ready=1 -> rsp_valid in cycle t+3. rdata=32'h8000_0010 (DW=64: 64'h7FFF_FFEF_8000_0010). err=0.
- mode=1, DEPTH=4, rsp_ready=0, 5 back-to-back commands -> 4 accepted, cmd_ready=0, outstanding=4. Release ready -> 4 in-order responses of all ones; cmd_ready returns after the first pop.
- err_en=1, err_mask=32'hF000_0000, err_match=32'h2000_0000. Reads 32'h2000_0004 then 32'h8000_0000 -> err=1 then err=0.
- mode=2, 200 random commands with random rsp_ready -> no valid drop or rdata change before handshake; response count = accept count; never accept while full.
- LAT=0, continuous valid/ready, mode=0 -> one response per cycle after 1-cycle fill; outstanding stays at 1.

Source files
------------

// File: rtl/e203_icb_stim_slave.sv
// Purpose: protocol-correct ICB slave responder for a fetch channel, with data patterns and error injection.
// Latency: a command accepted at edge t responds no earlier than cycle t+1+LAT; responses return strictly in order.
// Backpressure: cmd_ready drops when DEPTH entries are queued (or on LFSR stall in mode 2); a presented response holds until rsp_ready.
module e203_icb_stim_slave #(
  parameter int          DW    = 32,
  parameter int          AW    = 32,
  parameter int          DEPTH = 4,
  parameter int          LAT   = 2,
  parameter logic [31:0] SEED  = 32'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       err_en,
  input  logic [AW-1:0]              err_mask,
  input  logic [AW-1:0]              err_match,
  input  logic                       icb_cmd_valid,
  output logic                       icb_cmd_ready,
  input  logic [AW-1:0]              icb_cmd_addr,
  input  logic                       icb_cmd_read,
  output logic                       icb_rsp_valid,
  input  logic                       icb_rsp_ready,
  output logic                       icb_rsp_err,
  output logic [DW-1:0]              icb_rsp_rdata,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam int          PW        = $clog2(DEPTH);
  localparam int          OW        = $clog2(DEPTH+1);
  localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [3:0]  LAT_CNT   = 4'(LAT);

  // Queue storage: response data, error flag and remaining latency per slot.
  logic [DW-1:0]    data_q [DEPTH];
  logic [3:0]       cnt_q  [DEPTH];
  logic [DEPTH-1:0] err_q;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] count_q;
  logic          hold_q, hold_d;
  logic [31:0]   lfsr_q, lfsr_d;

  logic          full, empty, head_rdy, push, pop, push_err;
  logic [31:0]   addr32;
  logic [DW-1:0] addr_pat, push_data;

  // Galois LFSR step, free-running regardless of traffic.
  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  end

  assign full     = (count_q == OW'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_rdy = !empty && (cnt_q[rd_ptr_q] == 4'd0);

  // Ready depends only on registered state and mode, never on cmd_valid; full blocks even if a pop is in flight.
  assign icb_cmd_ready = !rst && !full && ((mode != 2'd2) || lfsr_q[0]);
  assign push          = icb_cmd_valid && icb_cmd_ready;

  // Once presented, hold_q overrides the random gate so valid and payload stay put until taken.
  assign icb_rsp_valid = head_rdy && (hold_q || (mode != 2'd2) || lfsr_q[1]);
  assign icb_rsp_rdata = icb_rsp_valid ? data_q[rd_ptr_q] : '0;
  assign icb_rsp_err   = icb_rsp_valid && err_q[rd_ptr_q];
  assign pop           = icb_rsp_valid && icb_rsp_ready;
  assign hold_d        = icb_rsp_valid && !icb_rsp_ready;
  assign outstanding   = count_q;

  // Payload captured at accept time; writes always return zero data.
  always_comb begin
    addr32   = 32'(icb_cmd_addr);
    addr_pat = {(DW/32){~addr32}};
    addr_pat[31:0] = addr32;
    push_data = '0;
    if (icb_cmd_read) begin
      case (mode)
        2'd0:    push_data = '0;
        2'd1:    push_data = '1;
        2'd2:    push_data = {(DW/32){lfsr_q}};
        default: push_data = addr_pat;
      endcase
    end
    push_err = err_en && ((icb_cmd_addr & err_mask) == err_match);
  end

  // Pointers, occupancy, hold flag and LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= LFSR_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      hold_q <= hold_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + OW'(1);
      else if (!push && pop) count_q <= count_q - OW'(1);
    end
  end

  // Slot write on accept; every other slot's latency counter saturates down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_q == PW'(i))) begin
          data_q[i] <= push_data;
          err_q[i]  <= push_err;
          cnt_q[i]  <= LAT_CNT;
        end else if (cnt_q[i] != 4'd0) begin
          cnt_q[i] <= cnt_q[i] - 4'd1;
        end
      end
    end
  end

endmodule
